// File: rtl/i3c_bus_monitor.sv
// I3C bus-condition monitor: deglitches SCL/SDA, emits edge pulses, detects
// START / repeated START / STOP and tracks bus busy/free/idle state.
module i3c_bus_monitor #(
  parameter int unsigned FilterCycles = 2,
  parameter int unsigned CntWidth     = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                scl_i,
  input  logic                sda_i,
  input  logic [CntWidth-1:0] t_free_i,
  input  logic [CntWidth-1:0] t_idle_i,
  output logic                scl_o,
  output logic                sda_o,
  output logic                scl_posedge_o,
  output logic                scl_negedge_o,
  output logic                sda_posedge_o,
  output logic                sda_negedge_o,
  output logic                start_det_o,
  output logic                rstart_det_o,
  output logic                stop_det_o,
  output logic                bus_busy_o,
  output logic                bus_free_o,
  output logic                bus_idle_o
);

  typedef enum logic {
    ST_WAIT,
    ST_BUSY
  } state_e;

  localparam logic [3:0]          FiltLimit = 4'(FilterCycles);
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] raw;
  logic [1:0] filt_q, filt_d;
  logic [3:0] mcnt_q [2];
  logic [3:0] mcnt_d [2];
  logic [1:0] rise, fall;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                start_cond, stop_cond, scl_stable_high;
  logic                start_d, rstart_d, stop_d;
  logic                start_q, rstart_q, stop_q;
  logic                scl_pos_q, scl_neg_q, sda_pos_q, sda_neg_q;

  assign raw = {sda_i, scl_i};

  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      mcnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (mcnt_q[i] + 4'd1 == FiltLimit) begin
          filt_d[i] = raw[i];
        end else begin
          mcnt_d[i] = mcnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

  // Conditions are judged on the filtered transition being registered this edge.
  assign scl_stable_high = filt_q[0] & filt_d[0];
  assign start_cond      = fall[1] & scl_stable_high;
  assign stop_cond       = rise[1] & scl_stable_high;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    rstart_d = 1'b0;
    stop_d   = 1'b0;
    if (!enable_i) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (start_cond) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
            cnt_d   = '0;
          end else if (&filt_q) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CntOne;
          end else begin
            cnt_d = '0;
          end
        end
        ST_BUSY: begin
          cnt_d = '0;
          if (start_cond) begin
            rstart_d = 1'b1;
          end else if (stop_cond) begin
            stop_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q    <= '1;
      mcnt_q[0] <= '0;
      mcnt_q[1] <= '0;
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      rstart_q  <= 1'b0;
      stop_q    <= 1'b0;
      scl_pos_q <= 1'b0;
      scl_neg_q <= 1'b0;
      sda_pos_q <= 1'b0;
      sda_neg_q <= 1'b0;
    end else begin
      filt_q    <= filt_d;
      mcnt_q[0] <= mcnt_d[0];
      mcnt_q[1] <= mcnt_d[1];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      rstart_q  <= rstart_d;
      stop_q    <= stop_d;
      scl_pos_q <= rise[0];
      scl_neg_q <= fall[0];
      sda_pos_q <= rise[1];
      sda_neg_q <= fall[1];
    end
  end

  assign scl_o         = filt_q[0];
  assign sda_o         = filt_q[1];
  assign scl_posedge_o = scl_pos_q;
  assign scl_negedge_o = scl_neg_q;
  assign sda_posedge_o = sda_pos_q;
  assign sda_negedge_o = sda_neg_q;
  assign start_det_o   = start_q;
  assign rstart_det_o  = rstart_q;
  assign stop_det_o    = stop_q;
  assign bus_busy_o    = (state_q == ST_BUSY);
  assign bus_free_o    = (state_q == ST_WAIT) && (cnt_q >= t_free_i);
  assign bus_idle_o    = (state_q == ST_WAIT) && (cnt_q >= t_idle_i);

endmodule
